// File: rtl/tff_count_ctrl_if.sv
// rtl/tff_count_ctrl_if.sv - control/status bundle between strobe logic and the T-FF count sequencer
interface tff_count_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             dir;
  logic [WIDTH-1:0] limit;
  logic             reload;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] t;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, pause, dir, limit, reload,
    input  q, t, busy, done
  );

  modport slave (
    input  start, stop, pause, dir, limit, reload,
    output q, t, busy, done
  );
endinterface

// File: rtl/tff_count_ctrl.sv
// rtl/tff_count_ctrl.sv - toggle-vector sequencer driving a T-FF bank as a terminal-count counter
module tff_count_ctrl #(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  tff_count_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q, t, lim_r;
  logic [WIDTH-1:0] up_vec, dn_vec, start_val, end_val;
  logic             dir_r, capture;
  logic             up_acc, dn_acc;

  // Ripple-style toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
  always_comb begin
    up_vec = '0;
    dn_vec = '0;
    up_acc = 1'b1;
    dn_acc = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      up_vec[i] = up_acc;
      dn_vec[i] = dn_acc;
      up_acc    = up_acc & q[i];
      dn_acc    = dn_acc & ~q[i];
    end
  end

  // In IDLE the load uses the live inputs, since they are captured on the same edge.
  assign start_val = (state == S_IDLE) ? (bus.dir ? '0 : bus.limit)
                                       : (dir_r   ? '0 : lim_r);
  assign end_val   = dir_r ? lim_r : '0;

  always_comb begin
    state_nxt = state;
    t         = '0;
    capture   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start) begin
          t         = q ^ start_val;
          capture   = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (bus.stop) begin
          state_nxt = S_IDLE;
        end else if (bus.pause) begin
          state_nxt = S_RUN;
        end else if (q == end_val) begin
          state_nxt = S_DONE;
        end else begin
          t = dir_r ? up_vec : dn_vec;
        end
      end
      S_DONE: begin
        if (bus.stop) begin
          state_nxt = S_IDLE;
        end else if (bus.reload) begin
          t         = q ^ start_val;
          state_nxt = S_RUN;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      q     <= '0;
      dir_r <= 1'b1;
      lim_r <= '0;
    end else begin
      state <= state_nxt;
      q     <= q ^ t;
      if (capture) begin
        dir_r <= bus.dir;
        lim_r <= bus.limit;
      end
    end
  end

  assign bus.q    = q;
  assign bus.t    = t;
  assign bus.busy = (state != S_IDLE);
  assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_tff_count_ctrl.sv
// tb/tb_tff_count_ctrl.sv - directed vector bench for tff_count_ctrl
module tb_tff_count_ctrl;
  localparam int WIDTH = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  tff_count_ctrl_if #(.WIDTH(WIDTH)) bus ();

  tff_count_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             start;
    logic             stop;
    logic             pause;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic             reload;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] t;
    logic             busy;
    logic             done;
  } vec_t;

  vec_t tbl[16];

  task automatic chk_v(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%b exp=%b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.pause  = 1'b0;
    bus.reload = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    idle_inputs();
    bus.dir   = 1'b1;
    bus.limit = 4'd0;

    // {start,stop,pause,dir,limit,reload, q,t,busy,done}: inputs for the cycle, outputs before its edge
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd0, 4'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd1, 4'd3, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd2, 4'd1, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd3, 4'd0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd3, 4'd0, 1'b1, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 4'd3, 4'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd3, 4'd3, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 4'd0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0};

    #1 rst = 1'b1;
    #1;
    chk_v("reset_q", bus.q, 4'd0);
    chk_v("reset_t", bus.t, 4'd0);
    chk_b("reset_busy", bus.busy, 1'b0);
    chk_b("reset_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Up count to 3, limit=0 run, down run from 1 with ignored start/dir change
    for (int i = 0; i < 16; i++) begin
      bus.start  = tbl[i].start;
      bus.stop   = tbl[i].stop;
      bus.pause  = tbl[i].pause;
      bus.dir    = tbl[i].dir;
      bus.limit  = tbl[i].limit;
      bus.reload = tbl[i].reload;
      #1;
      chk_v($sformatf("tbl%0d_q", i), bus.q, tbl[i].q);
      chk_v($sformatf("tbl%0d_t", i), bus.t, tbl[i].t);
      chk_b($sformatf("tbl%0d_busy", i), bus.busy, tbl[i].busy);
      chk_b($sformatf("tbl%0d_done", i), bus.done, tbl[i].done);
      step();
    end
    idle_inputs();

    // Down count from 10 with two pause cycles at q=7
    bus.start = 1'b1; bus.dir = 1'b0; bus.limit = 4'd10;
    step();
    bus.start = 1'b0; bus.dir = 1'b1;
    chk_v("dn_load_q", bus.q, 4'd10);
    step(); chk_v("dn_e1_q", bus.q, 4'd9);
    step(); chk_v("dn_e2_q", bus.q, 4'd8);
    step(); chk_v("dn_e3_q", bus.q, 4'd7);
    bus.pause = 1'b1;
    #1 chk_v("dn_pause1_t", bus.t, 4'd0);
    step(); chk_v("dn_e4_q", bus.q, 4'd7);
    #1 chk_v("dn_pause2_t", bus.t, 4'd0);
    step(); chk_v("dn_e5_q", bus.q, 4'd7);
    bus.pause = 1'b0;
    for (int e = 6; e <= 12; e++) begin
      step();
      chk_v($sformatf("dn_e%0d_q", e), bus.q, 4'(12 - e));
      chk_b($sformatf("dn_e%0d_done", e), bus.done, 1'b0);
    end
    step();
    chk_b("dn_e13_done", bus.done, 1'b1);
    chk_v("dn_e13_q", bus.q, 4'd0);
    step();
    chk_b("dn_idle_busy", bus.busy, 1'b0);

    // Full-range up run with reload back to 0
    bus.start = 1'b1; bus.dir = 1'b1; bus.limit = 4'd15; bus.reload = 1'b1;
    step();
    bus.start = 1'b0;
    chk_v("rl_load_q", bus.q, 4'd0);
    for (int e = 1; e <= 15; e++) begin
      if (e == 8) begin
        #1 chk_v("rl_7to8_t", bus.t, 4'b1111);
      end
      step();
      chk_v($sformatf("rl_e%0d_q", e), bus.q, 4'(e));
    end
    step();
    chk_b("rl_done", bus.done, 1'b1);
    chk_v("rl_done_q", bus.q, 4'd15);
    step();
    chk_v("rl_restart_q", bus.q, 4'd0);
    chk_b("rl_restart_busy", bus.busy, 1'b1);
    chk_b("rl_restart_done", bus.done, 1'b0);
    bus.reload = 1'b0; bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_b("rl_stop_busy", bus.busy, 1'b0);

    // Stop beats pause; start during RUN ignored
    bus.start = 1'b1; bus.dir = 1'b1; bus.limit = 4'd10;
    step();
    bus.start = 1'b0;
    step(); step();
    chk_v("sp_q2", bus.q, 4'd2);
    bus.start = 1'b1; bus.dir = 1'b0; bus.limit = 4'd12;
    step();
    bus.start = 1'b0;
    chk_v("sp_start_ignored_q", bus.q, 4'd3);
    step();
    chk_v("sp_q4", bus.q, 4'd4);
    bus.stop = 1'b1; bus.pause = 1'b1;
    #1 chk_v("sp_t", bus.t, 4'd0);
    step();
    idle_inputs();
    chk_v("sp_hold_q", bus.q, 4'd4);
    chk_b("sp_busy", bus.busy, 1'b0);
    chk_b("sp_done", bus.done, 1'b0);
    step();
    chk_b("sp_no_done", bus.done, 1'b0);

    // Asynchronous reset mid-run at q=5
    bus.start = 1'b1; bus.dir = 1'b1; bus.limit = 4'd10;
    step();
    bus.start = 1'b0;
    for (int e = 1; e <= 5; e++) step();
    chk_v("ar_pre_q", bus.q, 4'd5);
    #2 rst = 1'b1;
    #1;
    chk_v("ar_q", bus.q, 4'd0);
    chk_b("ar_busy", bus.busy, 1'b0);
    chk_b("ar_done", bus.done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 0; e < 12; e++) begin
      step();
      chk_b($sformatf("ar_post%0d_done", e), bus.done, 1'b0);
    end
    chk_b("ar_post_busy", bus.busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tff_count_ctrl.md
# tff_count_ctrl

Sequencer for a WIDTH-bit bank of T flip-flops, operated as a programmable terminal-count counter. The block generates the per-bit toggle vector each cycle, so the bank can load a start value, count up or down, pause, stop and auto-reload, all through toggles. It sits between software-style control strobes (start/stop/pause) and the toggle-register datapath, and reports busy/done to the surrounding logic.

## Interface
- WIDTH, 4: number of T flip-flops in the bank (≥2).

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a count run; sampled only in IDLE
- stop  in  1  abort; highest priority in RUN and DONE
- pause  in  1  hold count in RUN (t forced to 0)
- dir  in  1  1 = count up, 0 = count down; captured at accepted start
- limit  in  WIDTH  terminal value; captured at accepted start
- reload  in  1  sampled in DONE: 1 = restart run, 0 = return to IDLE
- q  out  WIDTH  T-FF bank state
- t  out  WIDTH  toggle vector applied at the next rising edge (combinational)
- busy  out  1  high in RUN and DONE
- done  out  1  high for exactly the DONE cycle

## Operation
- Datapath: every edge, q <= q ^ t. No other write path to q exists.
- Run values, captured at accepted start into dir_r and lim_r:
  - Up run: start value 0, end value lim_r.
  - Down run: start value lim_r, end value 0.
- Toggle vectors:
  - Count up: t[0]=1; t[i]=&q[i-1:0].
  - Count down: t[0]=1; t[i]=&~q[i-1:0].
  - Load: t = q ^ start value.
- States: IDLE, RUN, DONE (2-bit encoding, free choice).
- IDLE: t=0. On start=1, capture dir/limit, apply the load vector, and go to RUN. Otherwise stay.
- RUN, evaluated in priority order:
  1. stop=1: t=0, go to IDLE.
  2. pause=1: t=0, stay in RUN.
  3. q==end value: t=0, go to DONE.
  4. Otherwise apply the count vector and stay in RUN.
- DONE: done=1.
  - stop=1: t=0, go to IDLE.
  - reload=1: apply the load vector, go to RUN.
  - Otherwise t=0, go to IDLE.
- start is ignored while busy. dir and limit changes mid-run have no effect.
- Counting never wraps inside a run: the terminal check precedes the count step.
- busy = (state != IDLE). done = (state == DONE).

## Timing
- Reset (asynchronous): q=0, state IDLE, dir_r=1, lim_r=0, so t=0, busy=0, done=0. Reset mid-run aborts immediately, with no done pulse.
- With start seen at edge E0: q=start value after E0; busy rises after E0.
- Run length with no pause: |end − start| = limit count edges, then one DONE cycle.
  - done is high between edges E(limit+1) and E(limit+2).
  - q holds the end value through DONE.
- limit=0: RUN lasts 1 cycle, done after E1.
- Each pause cycle extends the run by exactly one cycle, with q frozen.
- Reload: the next run's start value appears after the DONE edge. There are no IDLE cycles between runs, and busy stays high.
- stop and pause asserted together in RUN: stop wins.

## Test plan
- Reset mid-run: rst pulsed asynchronously while in RUN with q=5 → q=0, busy=0, done=0 immediately; no done pulse follows.
- Up count: WIDTH=4, dir=1, limit=3, start pulse → q sequence 0,1,2,3,3 (DONE); done high one cycle after E4; then IDLE, busy=0, t=0.
- Down count with pause: dir=0, limit=10, pause held 2 cycles when q=7 → q sequence 10,9,8,7,7,7,6…0; done after edge 13; t=0 during the pause cycles.
- Reload and wrap boundary: dir=1, limit=15, reload=1 → q reaches 15, DONE for one cycle, next edge q=0 and busy stays 1. Also check t=4'b1111 on the 7→8 step.
- Stop priority: stop and pause asserted together in RUN at q=4 → IDLE next edge, q holds 4, no done pulse. A start pulse during RUN is ignored.
- Edge cases:
  - limit=0 up: done after E1, q=0 throughout.
  - Down run from limit=1 with dir changed mid-run: q goes 1 then 0 and completes normally; the dir change has no effect.
